// File: rtl/elipse_axil_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : elipse_axil_regbank
//  Purpose  : AXI4-Lite slave register bank for the ellipse coprocessor.
//             NUM_RW control words followed by NUM_RO status words. Word 0 is
//             CTRL/STAT: bit0 START (self-clearing pulse), bit1 DONE (sticky,
//             write-1-to-clear). AW and W channels are accepted independently.
//  Revision : 1.0  initial release
// ============================================================================
module elipse_axil_regbank #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 6,
    parameter int NUM_RW       = 4,
    parameter int NUM_RO       = 4
) (
    input  logic                                      ACLK,
    input  logic                                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
    input  logic [2:0]                                S_AXI_AWPROT,
    input  logic                                      S_AXI_AWVALID,
    output logic                                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]                   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
    input  logic                                      S_AXI_WVALID,
    output logic                                      S_AXI_WREADY,
    output logic [1:0]                                S_AXI_BRESP,
    output logic                                      S_AXI_BVALID,
    input  logic                                      S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
    input  logic [2:0]                                S_AXI_ARPROT,
    input  logic                                      S_AXI_ARVALID,
    output logic                                      S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]                   S_AXI_RDATA,
    output logic [1:0]                                S_AXI_RRESP,
    output logic                                      S_AXI_RVALID,
    input  logic                                      S_AXI_RREADY,
    output logic [C_DATA_WIDTH*NUM_RW-1:0]            ctrl_o,
    input  logic [(NUM_RO > 0 ? 32*NUM_RO : 32)-1:0]  status_i,
    output logic                                      start_o,
    input  logic                                      done_i
);

    localparam int              c_idx_w   = C_ADDR_WIDTH - 2;
    localparam int              c_nbytes  = C_DATA_WIDTH / 8;
    localparam logic [c_idx_w:0] c_num_rw = (c_idx_w+1)'(NUM_RW);
    localparam logic [1:0]      c_okay    = 2'b00;
    localparam logic [1:0]      c_slverr  = 2'b10;

    // Registered state and next-state values
    logic                    rdy_q;
    logic                    aw_held_q, aw_held_d;
    logic [c_idx_w-1:0]      aw_idx_q,  aw_idx_d;
    logic                    w_held_q,  w_held_d;
    logic [C_DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [c_nbytes-1:0]     w_strb_q,  w_strb_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    rvalid_q,  rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [C_DATA_WIDTH-1:0] regs_q [NUM_RW];
    logic [C_DATA_WIDTH-1:0] regs_d [NUM_RW];
    logic                    done_q,    done_d;
    logic                    start_q,   start_d;

    // Combinational helpers
    logic                    aw_hs, w_hs, ar_hs, commit, cmt_rw, w1c_done;
    logic [c_idx_w-1:0]      cmt_idx, ar_idx;
    logic [C_DATA_WIDTH-1:0] cmt_data, word0;
    logic [c_nbytes-1:0]     cmt_strb;
    logic                    unused_ok;

    // Readies stay low until the first edge after reset releases (rdy_q)
    assign S_AXI_AWREADY = rdy_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = rdy_q & ~w_held_q  & ~bvalid_q;
    assign S_AXI_ARREADY = rdy_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign start_o       = start_q;

    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit   = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign cmt_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
    assign cmt_data = w_held_q  ? w_data_q : S_AXI_WDATA;
    assign cmt_strb = w_held_q  ? w_strb_q : S_AXI_WSTRB;
    assign cmt_rw   = ({1'b0, cmt_idx} < c_num_rw);
    assign ar_idx   = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
    assign w1c_done = commit && (cmt_idx == '0) && cmt_strb[0] && cmt_data[1];

    // Word 0 as seen by software and the core: START reads 0, bit1 is DONE
    assign word0 = {regs_q[0][C_DATA_WIDTH-1:2], done_q, 1'b0};

    // Fields that are architecturally ignored
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], regs_q[0][1:0]};

    generate
        for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
            if (g == 0) begin : g_word0
                assign ctrl_o[C_DATA_WIDTH-1:0] = word0;
            end else begin : g_plain
                assign ctrl_o[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[g];
            end
        end
    endgenerate

    // Next-state logic for the write holding registers, commit and B channel
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        start_d   = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            regs_d[k] = regs_q[k];
        end

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = cmt_rw ? c_okay : c_slverr;
            for (int k = 0; k < NUM_RW; k++) begin
                if (cmt_idx == c_idx_w'(k)) begin
                    for (int b = 0; b < c_nbytes; b++) begin
                        if (cmt_strb[b]) begin
                            regs_d[k][b*8 +: 8] = cmt_data[b*8 +: 8];
                        end
                    end
                end
            end
            if ((cmt_idx == '0) && cmt_strb[0] && cmt_data[0]) begin
                start_d = 1'b1;
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
        end

        // START and DONE live outside the plain storage bits
        regs_d[0][1:0] = 2'b00;
        done_d = done_i | (done_q & ~w1c_done);
    end

    // Next-state logic for the read channel; reads see pre-write contents
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = c_slverr;
            for (int k = 0; k < NUM_RW; k++) begin
                if (ar_idx == c_idx_w'(k)) begin
                    rdata_d = (k == 0) ? word0 : regs_q[k];
                    rresp_d = c_okay;
                end
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if ({1'b0, ar_idx} == (c_idx_w+1)'(NUM_RW + k)) begin
                    rdata_d = status_i[k*32 +: 32];
                    rresp_d = c_okay;
                end
            end
        end
    end

    // State registers; reset drops any outstanding transaction
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            for (int k = 0; k < NUM_RW; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            rdy_q     <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            done_q    <= done_d;
            start_q   <= start_d;
            for (int k = 0; k < NUM_RW; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elipse_axil_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_elipse_axil_regbank
//  Purpose  : Directed self-checking bench for elipse_axil_regbank.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elipse_axil_regbank;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] ctrl, status;
    logic         start, done;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    logic [31:0] d;
    logic [1:0]  r;
    logic        st;
    int          s0;

    always #5 clk = ~clk;

    always @(posedge clk) if (start) start_cnt <= start_cnt + 1;

    elipse_axil_regbank dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_o(ctrl), .status_i(status), .start_o(start), .done_i(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Joint AW/W write; returns BRESP and start_o sampled when BVALID rises
    task automatic axi_write(input logic [5:0] a, input logic [31:0] dat, input logic [3:0] s,
                             output logic [1:0] resp, output logic st_o);
        logic aw_ok, w_ok, ha, hw;
        int cnt;
        awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0; cnt = 0;
        while (!(aw_ok && w_ok) && cnt < 20) begin
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk); #1;
            if (ha) begin aw_ok = 1'b1; awvalid = 1'b0; end
            if (hw) begin w_ok  = 1'b1; wvalid  = 1'b0; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("write_handshake_in_one_cycle", {30'd0, aw_ok, w_ok}, 32'd3);
        chk("bvalid_latency", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        st_o = start;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] dat, output logic [1:0] resp);
        logic ok, h;
        int cnt;
        araddr = a; arvalid = 1'b1; ok = 1'b0; cnt = 0;
        while (!ok && cnt < 20) begin
            h = arvalid && arready;
            @(posedge clk); #1;
            if (h) begin ok = 1'b1; arvalid = 1'b0; end
            cnt++;
        end
        arvalid = 1'b0;
        chk("rvalid_latency", {31'd0, rvalid}, 32'd1);
        dat = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        done = 1'b0;
        status = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hDEAD_BEEF};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
        chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_ctrl_lo", ctrl[63:0] == 64'd0 && ctrl[127:64] == 64'd0, 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {29'd0, awready, wready, arready}, 32'd7);

        // Basic writes and readback
        axi_write(6'h00, 32'h1111_1110, 4'hF, r, st); chk("w0_resp", r, 2'b00);
        axi_write(6'h04, 32'h2222_2222, 4'hF, r, st); chk("w1_resp", r, 2'b00);
        axi_write(6'h08, 32'h3333_3333, 4'hF, r, st); chk("w2_resp", r, 2'b00);
        axi_write(6'h0C, 32'h4444_4444, 4'hF, r, st); chk("w3_resp", r, 2'b00);
        axi_read(6'h00, d, r); chk("r0_data", d, 32'h1111_1110); chk("r0_resp", r, 2'b00);
        axi_read(6'h04, d, r); chk("r1_data", d, 32'h2222_2222); chk("r1_resp", r, 2'b00);
        axi_read(6'h08, d, r); chk("r2_data", d, 32'h3333_3333);
        axi_read(6'h0C, d, r); chk("r3_data", d, 32'h4444_4444); chk("r3_resp", r, 2'b00);
        chk("ctrl_word3", ctrl[127:96], 32'h4444_4444);

        // Same-cycle read and write of one register returns the old value
        awaddr = 6'h08; wdata = 32'h5555_5555; wstrb = 4'hF; araddr = 6'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_same_cycle_rdata", rdata, 32'h3333_3333);
        chk("rw_same_cycle_valids", {30'd0, bvalid, rvalid}, 32'd3);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h08, d, r); chk("r2_after_rw", d, 32'h5555_5555);

        // W arrives three cycles before AW
        wdata = 32'hA5A5_A5A4; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("early_w_wready_low", {31'd0, wready}, 32'd0);
        chk("early_w_awready_high", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("early_w_no_bvalid", {31'd0, bvalid}, 32'd0);
        awaddr = 6'h04; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("early_w_bvalid", {31'd0, bvalid}, 32'd1);
        chk("early_w_bresp", bresp, 2'b00);
        chk("no_accept_while_bvalid", {30'd0, awready, wready}, 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(6'h04, d, r); chk("early_w_readback", d, 32'hA5A5_A5A4);

        // Byte strobes
        axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, r, st);
        axi_write(6'h04, 32'h0000_0000, 4'b0101, r, st);
        axi_read(6'h04, d, r); chk("strobe_readback", d, 32'hFF00_FF00);

        // START pulse, DONE sticky and W1C
        axi_write(6'h00, 32'h0000_0000, 4'hF, r, st);
        s0 = start_cnt;
        axi_write(6'h00, 32'h0000_0001, 4'h1, r, st);
        chk("start_with_bvalid", {31'd0, st}, 32'd1);
        chk("start_low_after", {31'd0, start}, 32'd0);
        @(posedge clk); #1;
        chk("start_pulse_count", start_cnt - s0, 32'd1);
        axi_read(6'h00, d, r); chk("start_reads_zero", d, 32'h0);
        done = 1'b1; @(posedge clk); #1; done = 1'b0;
        axi_read(6'h00, d, r); chk("done_set", d, 32'h2);
        chk("ctrl_word0_done", ctrl[31:0], 32'h2);
        axi_write(6'h00, 32'h0000_0002, 4'h1, r, st);
        chk("w1c_no_start", {31'd0, st}, 32'd0);
        axi_read(6'h00, d, r); chk("done_cleared", d, 32'h0);
        done = 1'b1; @(posedge clk); #1; done = 1'b0;
        awaddr = 6'h00; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; done = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
        chk("w1c_collide_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
        axi_read(6'h00, d, r); chk("done_set_wins", d, 32'h2);

        // Read-only and unmapped space
        axi_read(6'h10, d, r); chk("ro0_data", d, 32'hDEAD_BEEF); chk("ro0_resp", r, 2'b00);
        axi_read(6'h1C, d, r); chk("ro3_data", d, 32'h4444_0003);
        axi_write(6'h10, 32'h1234_5678, 4'hF, r, st); chk("ro_write_slverr", r, 2'b10);
        axi_read(6'h10, d, r); chk("ro0_unchanged", d, 32'hDEAD_BEEF);
        chk("ctrl_after_ro_write", ctrl[63:32], 32'hFF00_FF00);
        axi_read(6'h3C, d, r); chk("unmapped_rresp", r, 2'b10); chk("unmapped_rdata", d, 32'h0);
        axi_write(6'h3C, 32'h1234_5678, 4'hF, r, st); chk("unmapped_bresp", r, 2'b10);

        // Reset while a B response is pending
        awaddr = 6'h04; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_reset_bvalid", {31'd0, bvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_bvalid", {31'd0, bvalid}, 32'd0);
        chk("async_reset_readies", {29'd0, awready, wready, arready}, 32'd0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ready", {29'd0, awready, wready, arready}, 32'd7);
        bready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale_bvalid", {31'd0, bvalid}, 32'd0);
        bready = 1'b0;
        axi_read(6'h04, d, r); chk("reg1_after_reset", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elipse_axil_regbank.md
Name: elipse_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank, successor to the fixed 4-register coprocessor slave interface.
- Provides NUM_RW control registers and NUM_RO status registers.
- Word 0 is a CTRL/STAT register: self-clearing START bit and sticky DONE bit. Sits between the AXI interconnect and the ellipse coprocessor core.
- Adds capabilities the previous interface lacked: independent AW/W acceptance, byte strobes, SLVERR on unmapped addresses, and start/done signalling.

Parameters:
- C_DATA_WIDTH, 32, AXI data width; must be 32.
- C_ADDR_WIDTH, 6, AXI address width; must be >= clog2(NUM_RW+NUM_RO)+2.
- NUM_RW, 4, read-write registers at word index 0..NUM_RW-1; range 1..16.
- NUM_RO, 4, read-only registers at word index NUM_RW..NUM_RW+NUM_RO-1; range 0..16.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- ctrl_o  out  32*NUM_RW  flat RW register contents; reg k occupies bits [32k+31:32k].
- status_i  in  32*NUM_RO  flat RO register inputs, sampled at the AR handshake.
- start_o  out  1  one-cycle start pulse to the core.
- done_i  in  1  core completion pulse.

Behaviour:
- Word index = ADDR[C_ADDR_WIDTH-1:2]; ADDR[1:0] ignored. Index >= NUM_RW+NUM_RO is unmapped.
- Reset (async, active-high): all registers 0; all AXI outputs 0 (AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=00); start_o=0; DONE=0.
- First cycle after ARESET deasserts: AWREADY=WREADY=ARREADY=1.
- Reset mid-transaction drops every outstanding transaction; no response is ever issued for it.

Write path:
- AW and W are held in independent single-entry holding registers. AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
- Commit occurs on the edge where both address and data are available, either held or handshaking this cycle. On that edge:
  - update the target register;
  - set BVALID=1 with BRESP (SLVERR if the index is unmapped or in the RO range, else OKAY);
  - clear both holding registers.
- AW and W handshaking in the same cycle: BVALID in the next cycle (latency 1). W arriving N cycles before AW: commit on the AW handshake edge.
- BVALID holds until BREADY; no new AW/W is accepted while BVALID=1.
- Byte lanes update only where WSTRB[b]=1. Writes to RO or unmapped words change nothing.

Word 0 (CTRL/STAT):
- bit0 START: a write with WSTRB[0]=1 and WDATA[0]=1 pulses start_o high for exactly 1 cycle, coincident with BVALID rising. START always reads 0.
- bit1 DONE: set by done_i=1. Writing 1 with WSTRB[0]=1 clears it (W1C). done_i and a clear on the same edge: set wins.
- bits[31:2]: plain RW.
- ctrl_o word 0 presents bit0=0 and bit1=DONE.

Read path:
- ARREADY = !RVALID. On AR handshake, RDATA and RRESP are registered and RVALID=1 in the next cycle.
- RW index returns register value (word 0 per CTRL/STAT rules). RO index returns the status_i slice. Unmapped index returns RDATA=0, RRESP=10.
- RVALID and RDATA stay stable until RREADY.
- Read and write channels are fully independent. A same-cycle read and write to one register returns the pre-write value.

Test Plan:
- Writes 0x11111110, 0x22222222, 0x33333333, 0x44444444 to 0x0/0x4/0x8/0xC, then read back -> 0x11111110, 0x22222222, 0x33333333, 0x44444444, all OKAY; each BVALID 1 cycle after the joint AW/W handshake.
- W valid 3 cycles before AW (data 0xA5A5A5A4, addr 0x4) -> WREADY drops after W handshake; BVALID the cycle after the AW handshake; readback 0xA5A5A5A4.
- Reg1=0xFFFFFFFF, then write 0x00000000 with WSTRB=0101 -> reads 0xFF00FF00.
- Write 0x1 to 0x0 -> start_o high exactly 1 cycle; done_i pulse -> read 0x0 returns 0x2; write 0x2 -> next read returns 0x0; done_i coincident with the W1C -> DONE remains 1.
- status_i word 0 = 0xDEADBEEF -> read 0x10 returns 0xDEADBEEF; write 0x10 -> SLVERR, value unchanged; read 0x3C -> RRESP=10, RDATA=0.
- Assert ARESET while BVALID=1 and BREADY=0 -> BVALID=0 immediately; reg1 reads 0 after release; no stale B response.
